// File: rtl/turbo_iter_sched.sv
// Iteration scheduler for a 7-symbol turbo decoder. It buffers one block of extrinsic LLRs
// and replays it through the interleave order (phase 0) or the deinterleave order (phase 1).
module turbo_iter_sched #(
    parameter int W        = 8,
    parameter int MAX_ITER = 4,
    parameter int ITER_W   = 4
) (
    input  logic              clk_p_i,
    input  logic              reset_p_i,
    input  logic              start_i,
    input  logic              early_stop_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [W-1:0]      in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [W-1:0]      out_data_o,
    output logic              out_last_o,
    output logic              phase_o,
    output logic [ITER_W-1:0] iter_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          wr_q, wr_d, rd_q, rd_d;
    logic                phase_q, phase_d;
    logic [ITER_W-1:0]   iter_q, iter_d, iter_inc;
    logic [W-1:0]        buf_q [7];
    logic                in_fire, out_fire;

    // Read-side address map; D is the inverse of I, so phase 1 undoes phase 0.
    function automatic logic [2:0] perm(input logic ph, input logic [2:0] idx);
        logic [2:0] r;
        r = 3'd6;
        if (!ph) begin
            case (idx)
                3'd0: r = 3'd1;
                3'd1: r = 3'd4;
                3'd2: r = 3'd2;
                3'd3: r = 3'd5;
                3'd4: r = 3'd3;
                3'd5: r = 3'd0;
                default: r = 3'd6;
            endcase
        end else begin
            case (idx)
                3'd0: r = 3'd5;
                3'd1: r = 3'd0;
                3'd2: r = 3'd2;
                3'd3: r = 3'd4;
                3'd4: r = 3'd1;
                3'd5: r = 3'd3;
                default: r = 3'd6;
            endcase
        end
        return r;
    endfunction

    assign in_ready_o  = (state_q == FILL);
    assign out_valid_o = (state_q == DRAIN);
    assign out_last_o  = (state_q == DRAIN) && (rd_q == 3'd6);
    assign out_data_o  = (state_q == DRAIN) ? buf_q[perm(phase_q, rd_q)] : '0;
    assign phase_o     = phase_q;
    assign iter_o      = iter_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);

    assign in_fire  = in_valid_i && in_ready_o;
    assign out_fire = out_valid_o && out_ready_i;
    assign iter_inc = iter_q + 1'b1;

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        phase_d = phase_q;
        iter_d  = iter_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = FILL;
                    phase_d = 1'b0;
                    iter_d  = '0;
                    wr_d    = 3'd0;
                    rd_d    = 3'd0;
                end
            end
            FILL: begin
                if (in_fire) begin
                    wr_d = wr_q + 3'd1;
                    if (wr_q == 3'd6) begin
                        state_d = DRAIN;
                        wr_d    = 3'd0;
                        rd_d    = 3'd0;
                    end
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    rd_d = rd_q + 3'd1;
                    if (rd_q == 3'd6) begin
                        rd_d = 3'd0;
                        if (!phase_q) begin
                            phase_d = 1'b1;
                            state_d = FILL;
                            wr_d    = 3'd0;
                        end else begin
                            iter_d = iter_inc;
                            if (iter_inc == ITER_W'(MAX_ITER) || early_stop_i) begin
                                state_d = DONE;
                            end else begin
                                phase_d = 1'b0;
                                state_d = FILL;
                                wr_d    = 3'd0;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_p_i) begin
        if (reset_p_i) begin
            state_q <= IDLE;
            wr_q    <= 3'd0;
            rd_q    <= 3'd0;
            phase_q <= 1'b0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            phase_q <= phase_d;
            iter_q  <= iter_d;
        end
    end

    // Buffer contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk_p_i) begin
        if (in_fire) buf_q[wr_q] <= in_data_i;
    end

endmodule

// File: tb/tb_turbo_iter_sched.sv
// Directed bench for turbo_iter_sched: a table of half-iterations plus hand-written
// sequences for backpressure, early stop and mid-frame reset.
module tb_turbo_iter_sched;

    logic       clk = 1'b0;
    logic       rst, start, es, in_valid, in_ready, out_valid, out_ready, out_last, phase, busy, done;
    logic [7:0] in_data, out_data;
    logic [3:0] iter;

    int n_cmp = 0;
    int n_bad = 0;

    turbo_iter_sched #(.W(8), .MAX_ITER(2), .ITER_W(4)) dut (
        .clk_p_i(clk), .reset_p_i(rst), .start_i(start), .early_stop_i(es),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_last_o(out_last), .phase_o(phase), .iter_o(iter), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] base;
        logic [7:0] exp [7];
        logic       ph;
        logic       stall;
        logic [3:0] iter_after;
    } vec_t;

    vec_t vt [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic feed(input logic [7:0] base);
        for (int k = 0; k < 7; k++) begin
            int t = 0;
            in_valid = 1'b1;
            in_data  = base + 8'(k);
            while (!in_ready && t < 20) begin
                step();
                t++;
            end
            if (t >= 20) chk("in_ready_timeout", 32'd0, 32'd1);
            step();
        end
        in_valid = 1'b0;
        chk("valid_after_fill", {31'd0, out_valid}, 32'd1);
        chk("ready_low_in_drain", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic drain(input logic [7:0] e [7], input logic ph, input bit stall, input bit stop);
        // junk on the input side must not touch the buffer outside FILL
        in_valid = 1'b1;
        in_data  = 8'hFF;
        es       = stop;
        for (int k = 0; k < 7; k++) begin
            int t = 0;
            if (stall && k == 2) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    step();
                    chk("stall_valid", {31'd0, out_valid}, 32'd1);
                    chk("stall_data", {24'd0, out_data}, {24'd0, e[2]});
                    chk("stall_last", {31'd0, out_last}, 32'd0);
                end
            end
            out_ready = 1'b1;
            while (!out_valid && t < 20) begin
                step();
                t++;
            end
            if (t >= 20) chk("out_valid_timeout", 32'd0, 32'd1);
            chk("drain_data", {24'd0, out_data}, {24'd0, e[k]});
            chk("drain_last", {31'd0, out_last}, {31'd0, (k == 6)});
            chk("drain_phase", {31'd0, phase}, {31'd0, ph});
            step();
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        es        = 1'b0;
        chk("exactly_7_words", {31'd0, out_valid}, 32'd0);
        chk("data_zero_idle", {24'd0, out_data}, 32'd0);
    endtask

    initial begin
        vt[0].base = 8'd10; vt[0].exp = '{8'd11, 8'd14, 8'd12, 8'd15, 8'd13, 8'd10, 8'd16};
        vt[0].ph = 1'b0; vt[0].stall = 1'b0; vt[0].iter_after = 4'd0;
        vt[1].base = 8'd20; vt[1].exp = '{8'd25, 8'd20, 8'd22, 8'd24, 8'd21, 8'd23, 8'd26};
        vt[1].ph = 1'b1; vt[1].stall = 1'b1; vt[1].iter_after = 4'd1;
        vt[2].base = 8'd30; vt[2].exp = '{8'd31, 8'd34, 8'd32, 8'd35, 8'd33, 8'd30, 8'd36};
        vt[2].ph = 1'b0; vt[2].stall = 1'b0; vt[2].iter_after = 4'd1;
        vt[3].base = 8'd40; vt[3].exp = '{8'd45, 8'd40, 8'd42, 8'd44, 8'd41, 8'd43, 8'd46};
        vt[3].ph = 1'b1; vt[3].stall = 1'b0; vt[3].iter_after = 4'd2;

        rst = 1'b1; start = 1'b0; es = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_iter", {28'd0, iter}, 32'd0);
        chk("rst_phase", {31'd0, phase}, 32'd0);

        // Full two-iteration run; start stays high through the first fill and must be ignored.
        start = 1'b1;
        step();
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("fill_data_zero", {24'd0, out_data}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            feed(vt[i].base);
            start = 1'b0;
            drain(vt[i].exp, vt[i].ph, vt[i].stall, 1'b0);
            chk("iter_after", {28'd0, iter}, {28'd0, vt[i].iter_after});
            if (i < 3) begin
                chk("next_fill_ready", {31'd0, in_ready}, 32'd1);
                chk("phase_after", {31'd0, phase}, {31'd0, ~vt[i].ph});
            end else begin
                chk("done_pulse", {31'd0, done}, 32'd1);
                step();
                chk("done_clear", {31'd0, done}, 32'd0);
                chk("idle_busy", {31'd0, busy}, 32'd0);
                chk("iter_hold", {28'd0, iter}, 32'd2);
                chk("phase_hold", {31'd0, phase}, 32'd1);
            end
        end

        // Early stop: ignored at the end of phase 0, honoured at the end of phase 1.
        start = 1'b1;
        step();
        start = 1'b0;
        feed(8'd10);
        drain(vt[0].exp, 1'b0, 1'b0, 1'b1);
        chk("es_ignored_ph0", {31'd0, in_ready}, 32'd1);
        feed(8'd20);
        drain(vt[1].exp, 1'b1, 1'b0, 1'b1);
        chk("es_done", {31'd0, done}, 32'd1);
        chk("es_iter", {28'd0, iter}, 32'd1);
        step();
        chk("es_idle_busy", {31'd0, busy}, 32'd0);
        chk("es_no_fill", {31'd0, in_ready}, 32'd0);

        // Mid-frame reset after three words, then a clean restart.
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            in_data = 8'd50 + 8'(j);
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_phase", {31'd0, phase}, 32'd0);
        chk("mid_rst_iter", {28'd0, iter}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        feed(8'd10);
        drain(vt[0].exp, 1'b0, 1'b0, 1'b0);
        chk("restart_phase", {31'd0, phase}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
